aud_dsp: RTL and testbench
==========================

Name: aud_dsp

Overview:
Playback sample engine that sits directly upstream of the audio player. It reads 16-bit signed PCM samples from external SRAM and applies speed control: fast (decimate), slow zero-order hold, or slow linear interpolation. It delivers one sample per DACLRCK frame on o_dac_data, and drives the player's enable.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, sample width (signed two's complement)
MIN_FRAME, 64, guaranteed minimum i_daclrck period in i_clk cycles (design budget, not checked)

Ports:
i_clk  in  1  bit clock (BCLK domain), single clock for the whole block
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  1-cycle pulse: start from IDLE, or resume from PAUSE
i_pause  in  1  1-cycle pulse: pause playback
i_stop  in  1  1-cycle pulse: stop and rewind
i_fast  in  1  1 = fast mode, 0 = slow mode
i_slow_mode  in  1  0 = zero-order hold, 1 = linear interpolation (slow mode only)
i_speed  in  3  N-1; speed factor N = 1..8
i_end_addr  in  ADDR_W  address of the last valid sample
i_daclrck  in  1  DAC left/right clock from codec
o_sram_addr  out  ADDR_W  SRAM read address
i_sram_data  in  DATA_W  SRAM read data, valid the cycle after address
o_dac_data  out  DATA_W  sample to player
o_en  out  1  player enable
o_state  out  2  0 IDLE, 1 PLAY, 2 PAUSE
o_done  out  1  1-cycle pulse when end of data is reached

Behaviour:
- Reset (async, immediate): o_sram_addr=0, o_dac_data=0, o_en=0, o_state=IDLE, o_done=0, internal k=0, divider cleared.
- Frame tick: i_daclrck is registered once. A falling edge (prev=1, cur=0) is the tick.
  - On the tick in PLAY with a prepared sample, o_dac_data loads the prepared value on the next clock edge. Latency is exactly 1 cycle after detection.
  - o_dac_data stays stable for the rest of the frame.
- Prefetch: after each load, the next sample is computed in the background (SRAM read plus optional divide). It must complete in ≤ 28 cycles.
- Top FSM:
  - IDLE -> PLAY on i_start: addr=0, k=0, prefetch first sample.
  - PLAY -> PAUSE on i_pause.
  - PAUSE -> PLAY on i_start.
  - Any state -> IDLE on i_stop: addr=0, o_dac_data=0, in-flight fetch or divide aborted.
  - PLAY -> IDLE when the end is passed; o_done pulses the same cycle as entry to IDLE.
- Command priority on simultaneous pulses: stop > pause > start. i_start in PLAY and i_pause outside PLAY are ignored.
- o_en = 1 only in PLAY after the first sample is loaded. In PAUSE, o_en=0 and o_dac_data holds its last value. Ticks in PAUSE or IDLE are ignored.
- Speed mode and N are latched only when k==0 (a source-sample boundary). Changes mid-interpolation take effect at the next source sample.
- Fast mode: output s[a], then a += N. End when a > i_end_addr; the last output sample is s[a] with a ≤ end.
- Slow ZOH mode: output s[a] N times (k = 0..N-1), then a += 1.
- Slow linear mode:
  - Output = trunc_toward_zero((s0*(N-k) + s1*k) / N), where s0=s[a] and s1=s[a+1].
  - Intermediates are 20-bit signed.
  - If a+1 > end, s1 = s0.
  - N=1 gives a plain copy.
- Slow-mode end: after the k=N-1 output of a = end, go to IDLE on the following tick.
- Address wrap is never used: end ≤ 2^ADDR_W-1, and the a > end comparison uses ADDR_W+1 bits.

Decomposition:
- Package aud_pkg: state enum (IDLE/PLAY/PAUSE), ADDR_W, DATA_W, SPEED_W=3, internal fetch-substate enum (F_IDLE, F_RD0, F_RD1, F_DIV, F_RDY).
- Sub-module aud_sdiv: sequential signed restoring divider.
  - 20-bit dividend, 4-bit divisor, truncating quotient.
  - start/done handshake, ≤ 22 cycles.

Test Plan:
1. SRAM model s[a]=3a, end=9, fast=1, N=1, ticks every 64 cycles -> o_dac_data = 0,3,…,27, one per tick, each 1 cycle after the detected edge. Then o_done pulse, o_en=0, o_state=0.
2. s[a]=a, end=20, fast=1, N=4 -> outputs 0,4,8,12,16,20, then done.
3. s=100,200,…, slow ZOH, N=4 -> 100,100,100,100,200,200,… Change N to 2 mid-run -> change applies only at the next k=0.
4. Slow linear:
   - N=4, s0=100, s1=-100 -> 100,50,0,-50,-100.
   - N=3, s0=0, s1=-1 -> 0,0,0 (truncation toward zero).
   - At end, s1=s0 -> constant output.
5. Pause after the 3rd sample: o_en=0, data held, ticks ignored. Start resumes with the 4th sample. Stop plus pause in the same cycle -> IDLE, addr=0, o_dac_data=0.
6. i_rst_n low mid-divide in PLAY -> all outputs 0 and o_state=0 immediately, before any clock edge. After release, i_start replays from addr 0.

Source files
------------

// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aud_pkg
//  Description : Shared types and constants for the aud_dsp playback engine.
//                Provides the top-level state enum, the background fetch
//                sub-state enum, bus widths and a sign-extension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aud_pkg;

    localparam int ADDR_W    = 20;  // SRAM word-address width
    localparam int DATA_W    = 16;  // signed PCM sample width
    localparam int SPEED_W   = 3;   // speed field carries N-1, N = 1..8
    localparam int ACC_W     = 20;  // interpolation intermediate width
    localparam int DIV_W     = 4;   // divisor width (N = 1..8, unsigned)
    localparam int MIN_FRAME = 64;  // minimum DACLRCK period in clk cycles

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        F_IDLE = 3'd0,  // nothing in flight
        F_RD0  = 3'd1,  // address of s[a] on the bus
        F_RD1  = 3'd2,  // s[a] (then optionally s[a+1]) arriving
        F_DIV  = 3'd3,  // waiting for the divider
        F_RDY  = 3'd4   // prepared sample waiting for a frame tick
    } fetch_t;

    function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aud_if.sv
`default_nettype none
// ============================================================================
//  Module      : aud_if
//  Description : Sample-path bundle of aud_dsp: SRAM read port and the
//                player-side DAC connection. Signal names are written from
//                the engine's point of view.
//  Ports       : o_sram_addr  - SRAM word address
//                i_sram_data  - SRAM read data, valid one cycle after address
//                i_daclrck    - codec left/right frame clock
//                o_dac_data   - sample presented to the player
//                o_en         - player enable
//  Revision    : 1.0 - initial release
// ============================================================================
interface aud_if;
    import aud_pkg::*;

    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] i_sram_data;
    logic              i_daclrck;
    logic [DATA_W-1:0] o_dac_data;
    logic              o_en;

    // Engine side
    modport master (
        output o_sram_addr,
        input  i_sram_data,
        input  i_daclrck,
        output o_dac_data,
        output o_en
    );

    // SRAM / codec / player side
    modport slave (
        input  o_sram_addr,
        output i_sram_data,
        output i_daclrck,
        input  o_dac_data,
        input  o_en
    );

endinterface
`default_nettype wire

// File: rtl/aud_sdiv.sv
`default_nettype none
// ============================================================================
//  Module      : aud_sdiv
//  Description : Sequential signed restoring divider. Divides a 20-bit two's
//                complement dividend by a positive 4-bit divisor, quotient
//                truncated toward zero. One quotient bit per cycle; o_done
//                pulses 21 cycles after i_start. i_abort kills a divide.
//  Ports       : i_clk, i_rst_n   - clock, async active-low reset
//                i_start          - 1-cycle pulse, operands sampled
//                i_abort          - cancel any divide in progress
//                i_dividend       - signed dividend
//                i_divisor        - unsigned divisor (must be non-zero)
//                o_done           - 1-cycle pulse, quotient valid
//                o_quotient       - low DATA_W bits of signed quotient
//  Revision    : 1.0 - initial release
// ============================================================================
module aud_sdiv
    import aud_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ACC_W-1:0]  i_dividend,
    input  logic [DIV_W-1:0]  i_divisor,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quotient
);

    localparam logic [4:0] CNT_INIT = 5'(ACC_W);

    logic             busy_q, busy_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic [ACC_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] dvs_q, dvs_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;

    logic [DIV_W:0]    w_rem_sh;
    logic              w_fit;
    logic [DATA_W-1:0] w_mag;

    // Partial remainder stays below the divisor, so DIV_W bits hold it; the
    // shifted value needs one extra bit only for the compare.
    assign w_rem_sh = {rem_q, quo_q[ACC_W-1]};
    assign w_fit    = (w_rem_sh >= {1'b0, dvs_q});

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        neg_d  = neg_q;
        done_d = 1'b0;

        if (i_abort) begin
            busy_d = 1'b0;
            cnt_d  = 5'd0;
        end else if (i_start) begin
            busy_d = 1'b1;
            cnt_d  = CNT_INIT;
            rem_d  = '0;
            dvs_d  = i_divisor;
            neg_d  = i_dividend[ACC_W-1];
            // Divide magnitudes; -2^19 maps to 2^19 which still fits unsigned.
            quo_d  = i_dividend[ACC_W-1] ? (~i_dividend + 1'b1) : i_dividend;
        end else if (busy_q) begin
            quo_d = {quo_q[ACC_W-2:0], w_fit};
            rem_d = w_fit ? (w_rem_sh[DIV_W-1:0] - dvs_q) : w_rem_sh[DIV_W-1:0];
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= 5'd0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            neg_q  <= neg_d;
            done_q <= done_d;
        end
    end

    assign w_mag      = quo_q[DATA_W-1:0];
    assign o_quotient = neg_q ? (~w_mag + 1'b1) : w_mag;
    assign o_done     = done_q;

endmodule
`default_nettype wire

// File: rtl/aud_dsp.sv
`default_nettype none
// ============================================================================
//  Module      : aud_dsp
//  Description : Playback sample engine. Reads signed PCM from SRAM and
//                applies speed control (fast decimation, slow zero-order
//                hold or slow linear interpolation), delivering one sample
//                per DACLRCK frame to the audio player.
//  Ports       : i_clk, i_rst_n        - clock, async active-low reset
//                i_start/i_pause/i_stop - 1-cycle command pulses
//                i_fast, i_slow_mode    - speed mode select
//                i_speed                - N-1, N = 1..8
//                i_end_addr             - address of last valid sample
//                bus (aud_if.master)    - SRAM read port and DAC output
//                o_state                - 0 IDLE, 1 PLAY, 2 PAUSE
//                o_done                 - pulse on reaching end of data
//  Revision    : 1.0 - initial release
// ============================================================================
module aud_dsp
    import aud_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_stop,
    input  logic               i_fast,
    input  logic               i_slow_mode,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic [ADDR_W-1:0]  i_end_addr,
    aud_if.master              bus,
    output logic [1:0]         o_state,
    output logic               o_done
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    fetch_t              fetch_q, fetch_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;        // current source address a
    logic [SPEED_W-1:0]  k_q, k_d;              // repeat index within a
    logic [SPEED_W-1:0]  n_q, n_d;              // latched N-1
    logic                fast_q, fast_d;
    logic                lin_q, lin_d;
    logic                fin_q, fin_d;          // last sample already output
    logic                primed_q, primed_d;    // a sample has been loaded
    logic                en_q, en_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   dac_q, dac_d;
    logic [DATA_W-1:0]   pre_q, pre_d;          // prepared next sample
    logic [DATA_W-1:0]   s0_q, s0_d;
    logic                rd_s1_q, rd_s1_d;      // second read (s[a+1]) pending
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic                lrck_q, lrck_d;

    logic                w_tick;
    logic [DIV_W-1:0]    w_n;
    logic [DIV_W-1:0]    w_nk;
    logic [ADDR_W:0]     w_a_ext;
    logic [ADDR_W:0]     w_end_ext;
    logic [ADDR_W:0]     w_fast_next;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic                w_need_s1;
    logic [ACC_W-1:0]    w_num;
    logic                w_div_start;
    logic                w_div_abort;
    logic                w_div_done;
    logic [DATA_W-1:0]   w_quo;

    // Frame tick: falling edge of DACLRCK against its registered copy.
    assign w_tick      = lrck_q & ~bus.i_daclrck;

    assign w_n         = {1'b0, n_q} + 4'd1;
    assign w_nk        = w_n - {1'b0, k_q};
    assign w_a_ext     = {1'b0, addr_q};
    assign w_end_ext   = {1'b0, i_end_addr};
    assign w_fast_next = w_a_ext + {{(ADDR_W+1-DIV_W){1'b0}}, w_n};
    assign w_addr_inc  = addr_q + ADDR_ONE;

    // The neighbour sample is needed only for a real interpolation point; at
    // the end of data s1 falls back to s0, making the result exactly s0.
    assign w_need_s1   = lin_q && (k_q != '0) && (w_a_ext < w_end_ext);

    // s0*(N-k) + s1*k; s1 is on the SRAM bus during the second read cycle.
    assign w_num = $signed(sext(s0_q)) * $signed({{(ACC_W-DIV_W){1'b0}}, w_nk})
                 + $signed(sext(bus.i_sram_data))
                 * $signed({{(ACC_W-SPEED_W){1'b0}}, k_q});

    aud_sdiv u_div (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (w_div_start),
        .i_abort    (w_div_abort),
        .i_dividend (w_num),
        .i_divisor  (w_n),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    always_comb begin
        state_d     = state_q;
        fetch_d     = fetch_q;
        addr_d      = addr_q;
        k_d         = k_q;
        n_d         = n_q;
        fast_d      = fast_q;
        lin_d       = lin_q;
        fin_d       = fin_q;
        primed_d    = primed_q;
        en_d        = en_q;
        done_d      = 1'b0;
        dac_d       = dac_q;
        pre_d       = pre_q;
        s0_d        = s0_q;
        rd_s1_d     = rd_s1_q;
        sram_addr_d = sram_addr_q;
        lrck_d      = bus.i_daclrck;
        w_div_start = 1'b0;
        w_div_abort = 1'b0;

        // ---------------- background fetch ----------------
        case (fetch_q)
            F_RD0: begin
                // Pipeline the neighbour address right behind s[a].
                if (w_need_s1) begin
                    sram_addr_d = w_addr_inc;
                end
                rd_s1_d = 1'b0;
                fetch_d = F_RD1;
            end
            F_RD1: begin
                if (!rd_s1_q) begin
                    s0_d = bus.i_sram_data;
                    if (w_need_s1) begin
                        rd_s1_d = 1'b1;
                    end else begin
                        pre_d   = bus.i_sram_data;
                        fetch_d = F_RDY;
                    end
                end else begin
                    w_div_start = 1'b1;
                    rd_s1_d     = 1'b0;
                    fetch_d     = F_DIV;
                end
            end
            F_DIV: begin
                if (w_div_done) begin
                    pre_d   = w_quo;
                    fetch_d = F_RDY;
                end
            end
            default: ;
        endcase

        // ---------------- commands and frame ticks ----------------
        if (i_stop) begin
            state_d     = IDLE;
            fetch_d     = F_IDLE;
            addr_d      = '0;
            k_d         = '0;
            fin_d       = 1'b0;
            primed_d    = 1'b0;
            en_d        = 1'b0;
            dac_d       = '0;
            rd_s1_d     = 1'b0;
            sram_addr_d = '0;
            w_div_start = 1'b0;
            w_div_abort = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_d     = PLAY;
                        addr_d      = '0;
                        k_d         = '0;
                        fast_d      = i_fast;
                        lin_d       = ~i_fast & i_slow_mode;
                        n_d         = i_speed;
                        fin_d       = 1'b0;
                        primed_d    = 1'b0;
                        en_d        = 1'b0;
                        rd_s1_d     = 1'b0;
                        sram_addr_d = '0;
                        fetch_d     = F_RD0;
                    end
                end
                PLAY: begin
                    if (i_pause) begin
                        state_d = PAUSE;
                        en_d    = 1'b0;
                    end else if (w_tick) begin
                        if (fin_q) begin
                            state_d  = IDLE;
                            done_d   = 1'b1;
                            en_d     = 1'b0;
                            fin_d    = 1'b0;
                            primed_d = 1'b0;
                            addr_d   = '0;
                            k_d      = '0;
                        end else if (fetch_q == F_RDY) begin
                            dac_d    = pre_q;
                            en_d     = 1'b1;
                            primed_d = 1'b1;
                            fetch_d  = F_IDLE;
                            if (fast_q) begin
                                // 21-bit compare: a+N never wraps.
                                if (w_fast_next > w_end_ext) begin
                                    fin_d = 1'b1;
                                end else begin
                                    addr_d      = w_fast_next[ADDR_W-1:0];
                                    k_d         = '0;
                                    fast_d      = i_fast;
                                    lin_d       = ~i_fast & i_slow_mode;
                                    n_d         = i_speed;
                                    sram_addr_d = w_fast_next[ADDR_W-1:0];
                                    fetch_d     = F_RD0;
                                end
                            end else if (k_q == n_q) begin
                                if (addr_q >= i_end_addr) begin
                                    fin_d = 1'b1;
                                end else begin
                                    // New source sample: mode/N may change here.
                                    addr_d      = w_addr_inc;
                                    k_d         = '0;
                                    fast_d      = i_fast;
                                    lin_d       = ~i_fast & i_slow_mode;
                                    n_d         = i_speed;
                                    sram_addr_d = w_addr_inc;
                                    fetch_d     = F_RD0;
                                end
                            end else begin
                                k_d         = k_q + 3'd1;
                                sram_addr_d = addr_q;
                                fetch_d     = F_RD0;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (i_start) begin
                        state_d = PLAY;
                        en_d    = primed_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            fetch_q     <= F_IDLE;
            addr_q      <= '0;
            k_q         <= '0;
            n_q         <= '0;
            fast_q      <= 1'b0;
            lin_q       <= 1'b0;
            fin_q       <= 1'b0;
            primed_q    <= 1'b0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
            dac_q       <= '0;
            pre_q       <= '0;
            s0_q        <= '0;
            rd_s1_q     <= 1'b0;
            sram_addr_q <= '0;
            lrck_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_q     <= fetch_d;
            addr_q      <= addr_d;
            k_q         <= k_d;
            n_q         <= n_d;
            fast_q      <= fast_d;
            lin_q       <= lin_d;
            fin_q       <= fin_d;
            primed_q    <= primed_d;
            en_q        <= en_d;
            done_q      <= done_d;
            dac_q       <= dac_d;
            pre_q       <= pre_d;
            s0_q        <= s0_d;
            rd_s1_q     <= rd_s1_d;
            sram_addr_q <= sram_addr_d;
            lrck_q      <= lrck_d;
        end
    end

    assign bus.o_sram_addr = sram_addr_q;
    assign bus.o_dac_data  = dac_q;
    assign bus.o_en        = en_q;
    assign o_state         = state_q;
    assign o_done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aud_dsp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aud_dsp
//  Description : Directed self-checking bench for aud_dsp. A synchronous
//                SRAM model answers reads one cycle after the address; the
//                bench drives DACLRCK frames of 64 clocks and compares every
//                loaded sample against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aud_dsp;

    logic        clk;
    logic        rst_n;
    logic        start, pause, stop;
    logic        fast, slow_mode;
    logic [2:0]  speed;
    logic [19:0] end_addr;
    logic [1:0]  state;
    logic        done;

    logic [15:0] mem [64];

    int n_chk  = 0;
    int n_fail = 0;

    aud_if bus();

    aud_dsp dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_pause     (pause),
        .i_stop      (stop),
        .i_fast      (fast),
        .i_slow_mode (slow_mode),
        .i_speed     (speed),
        .i_end_addr  (end_addr),
        .bus         (bus),
        .o_state     (state),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: data for the address seen this cycle appears next cycle.
    always @(posedge clk) begin
        bus.i_sram_data <= (bus.o_sram_addr < 20'd64) ? mem[bus.o_sram_addr[5:0]] : 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    // One 64-clock frame; the sample must appear one clock after the fall.
    task automatic frame(input logic [15:0] exp, input string tag);
        bus.i_daclrck = 1'b0;
        cyc(1);
        chk({tag, "_data"}, 32'(bus.o_dac_data), 32'(exp));
        chk({tag, "_en"}, 32'(bus.o_en), 32'd1);
        cyc(31);
        bus.i_daclrck = 1'b1;
        cyc(31);
        chk({tag, "_hold"}, 32'(bus.o_dac_data), 32'(exp));
        cyc(1);
    endtask

    task automatic frame_end(input string tag);
        bus.i_daclrck = 1'b0;
        cyc(1);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_en"}, 32'(bus.o_en), 32'd0);
        cyc(1);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        cyc(30);
        bus.i_daclrck = 1'b1;
        cyc(32);
    endtask

    task automatic do_stop(input string tag);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_dac"}, 32'(bus.o_dac_data), 32'd0);
        chk({tag, "_addr"}, 32'(bus.o_sram_addr), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        fast = 1'b1; slow_mode = 1'b0; speed = 3'd0; end_addr = 20'd9;
        bus.i_daclrck = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 16'(3 * i);
        cyc(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_dac", 32'(bus.o_dac_data), 32'd0);
        chk("rst_en", 32'(bus.o_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(bus.o_sram_addr), 32'd0);
        rst_n = 1'b1;
        cyc(3);

        // 1: fast N=1, s[a]=3a, end=9
        pulse_start();
        chk("t1_play", 32'(state), 32'd1);
        chk("t1_en_pre", 32'(bus.o_en), 32'd0);
        cyc(39);
        for (int i = 0; i < 10; i++) frame(16'(3 * i), "t1");
        frame_end("t1_end");

        // 2: fast N=4, s[a]=a, end=20
        for (int i = 0; i < 64; i++) mem[i] = 16'(i);
        end_addr = 20'd20; speed = 3'd3;
        pulse_start(); cyc(39);
        for (int i = 0; i < 6; i++) frame(16'(4 * i), "t2");
        frame_end("t2_end");

        // 3: slow ZOH N=4, N changed to 2 mid-sample
        for (int i = 0; i < 64; i++) mem[i] = 16'(100 * (i + 1));
        fast = 1'b0; slow_mode = 1'b0; speed = 3'd3; end_addr = 20'd9;
        pulse_start(); cyc(39);
        for (int i = 0; i < 4; i++) frame(16'd100, "t3_a0");
        frame(16'd200, "t3_a1k0");
        speed = 3'd1;
        for (int i = 0; i < 3; i++) frame(16'd200, "t3_a1");
        frame(16'd300, "t3_a2"); frame(16'd300, "t3_a2");
        frame(16'd400, "t3_a3"); frame(16'd400, "t3_a3");
        do_stop("t3_stop");
        cyc(5);

        // 4a: linear N=4, 100 -> -100, end=1 (end holds s0)
        mem[0] = 16'd100; mem[1] = 16'hFF9C; mem[2] = 16'd7;
        slow_mode = 1'b1; speed = 3'd3; end_addr = 20'd1;
        pulse_start(); cyc(39);
        frame(16'd100, "t4_k0"); frame(16'd50, "t4_k1");
        frame(16'd0, "t4_k2");   frame(16'hFFCE, "t4_k3");
        for (int i = 0; i < 4; i++) frame(16'hFF9C, "t4_end");
        frame_end("t4_fin");

        // 4b: linear N=3, 0 -> -1, truncation toward zero
        mem[0] = 16'd0; mem[1] = 16'hFFFF; speed = 3'd2;
        pulse_start(); cyc(39);
        for (int i = 0; i < 3; i++) frame(16'd0, "t4b_trunc");
        for (int i = 0; i < 3; i++) frame(16'hFFFF, "t4b_end");
        frame_end("t4b_fin");

        // 5: pause / resume / stop+pause
        for (int i = 0; i < 64; i++) mem[i] = 16'(3 * i);
        fast = 1'b1; slow_mode = 1'b0; speed = 3'd0; end_addr = 20'd9;
        pulse_start(); cyc(39);
        frame(16'd0, "t5"); frame(16'd3, "t5"); frame(16'd6, "t5");
        pause = 1'b1; cyc(1); pause = 1'b0;
        chk("t5_pause_state", 32'(state), 32'd2);
        chk("t5_pause_en", 32'(bus.o_en), 32'd0);
        chk("t5_pause_dac", 32'(bus.o_dac_data), 32'd6);
        bus.i_daclrck = 1'b0; cyc(2);
        chk("t5_pause_tick", 32'(bus.o_dac_data), 32'd6);
        cyc(30); bus.i_daclrck = 1'b1; cyc(32);
        pulse_start();
        chk("t5_resume_state", 32'(state), 32'd1);
        chk("t5_resume_en", 32'(bus.o_en), 32'd1);
        frame(16'd9, "t5_resume");
        stop = 1'b1; pause = 1'b1; cyc(1); stop = 1'b0; pause = 1'b0;
        chk("t5_sp_state", 32'(state), 32'd0);
        chk("t5_sp_dac", 32'(bus.o_dac_data), 32'd0);
        chk("t5_sp_addr", 32'(bus.o_sram_addr), 32'd0);
        cyc(5);

        // 6: async reset while the divider is busy
        mem[0] = 16'd100; mem[1] = 16'hFF9C;
        fast = 1'b0; slow_mode = 1'b1; speed = 3'd3; end_addr = 20'd1;
        pulse_start(); cyc(39);
        bus.i_daclrck = 1'b0;
        cyc(1);
        chk("t6_first", 32'(bus.o_dac_data), 32'd100);
        cyc(6);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_state", 32'(state), 32'd0);
        chk("t6_rst_dac", 32'(bus.o_dac_data), 32'd0);
        chk("t6_rst_en", 32'(bus.o_en), 32'd0);
        chk("t6_rst_addr", 32'(bus.o_sram_addr), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        bus.i_daclrck = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        pulse_start(); cyc(39);
        frame(16'd100, "t6_replay_k0");
        frame(16'd50, "t6_replay_k1");
        do_stop("t6_stop");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
